// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Start/done handshake; a result is produced WIDTH cycles after acceptance.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             load, last;
  logic             d_bit, br_next;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs.
  assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign res_next = {d_bit, res_sr[WIDTH-1:1]};

  assign busy = (state == SHIFT);

  // NOTE: state register uses non-blocking assignment; the next-state logic
  // below is a pure always_comb with every output defaulted first, so no latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every datapath flop is cleared by rst_n, so an aborted operation
  // leaves no stale operands, borrow or partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        a_sr   <= a;
        b_sr   <= b;
        br     <= bin;
        res_sr <= '0;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        br     <= br_next;
        res_sr <= res_next;
        cnt    <= cnt + 1'b1;
        // Outputs move only here, so they hold the previous result mid-operation.
        if (last) begin
          diff <= res_next;
          bout <= br_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with hand-computed results.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             busy, done, bout;
  logic [WIDTH-1:0] diff;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, required finish earlier");
    $fatal(1, "timeout");
  end

  // Waits (bounded) for done, starting #1 after the accepting edge.
  task automatic wait_done(output int cyc, output logic busy_ok, output logic hold_ok);
    logic [WIDTH-1:0] prev_d;
    logic             prev_b;
    prev_d  = diff;
    prev_b  = bout;
    cyc     = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (diff !== prev_d || bout !== prev_b) hold_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi,
                        input logic [WIDTH-1:0] exp_d, input logic exp_b, input string name);
    int   cyc;
    logic busy_ok, hold_ok;
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, busy_ok, hold_ok);
    checks++; if (cyc !== WIDTH) begin errors++; $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, WIDTH); end
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL %s busy_during: got %b, want 1", name, busy_ok); end
    checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL %s hold_during: got %b, want 1", name, hold_ok); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b, want 0", name, busy); end
    checks++; if (diff !== exp_d) begin errors++; $display("FAIL %s diff: got %b, want %b", name, diff, exp_d); end
    checks++; if (bout !== exp_b) begin errors++; $display("FAIL %s bout: got %b, want %b", name, bout, exp_b); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse_width: got %b, want 0", name, done); end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b, want 0", done); end
    checks++; if (diff !== 4'b0000) begin errors++; $display("FAIL reset diff: got %b, want 0000", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset bout: got %b, want 0", bout); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, "basic_5m3");
    run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, "neg_3m5");
    run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, "wrap_0m0m1");
    run_op(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, "equal_fm_f");
    run_op(4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0, "bin_am5m1");
    run_op(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, "max_borrow");
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic busy_ok, hold_ok;
    a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    wait_done(cyc, busy_ok, hold_ok);
    checks++; if (cyc !== WIDTH) begin errors++; $display("FAIL b2b first_latency: got %0d, want %0d", cyc, WIDTH); end
    checks++; if (diff !== 4'b0010) begin errors++; $display("FAIL b2b first_diff: got %b, want 0010", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL b2b first_bout: got %b, want 0", bout); end
    a = 4'b1000; b = 4'b0001;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b second_accept busy: got %b, want 1", busy); end
    wait_done(cyc, busy_ok, hold_ok);
    checks++; if (cyc + 1 !== WIDTH + 1) begin errors++; $display("FAIL b2b spacing: got %0d cycles, want %0d", cyc + 1, WIDTH + 1); end
    checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL b2b hold_0010: got %b, want 1", hold_ok); end
    checks++; if (diff !== 4'b0111) begin errors++; $display("FAIL b2b second_diff: got %b, want 0111", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL b2b second_bout: got %b, want 0", bout); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start();
    int   cyc;
    logic busy_ok, hold_ok;
    a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 4'b1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, busy_ok, hold_ok);
    checks++; if (cyc + 3 !== WIDTH) begin errors++; $display("FAIL ignore latency: got %0d, want %0d", cyc + 3, WIDTH); end
    checks++; if (diff !== 4'b0010) begin errors++; $display("FAIL ignore diff: got %b, want 0010", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL ignore bout: got %b, want 0", bout); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore not_queued busy: got %b, want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int seen;
    a = 4'b1010; b = 4'b0101; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b, want 0", busy); end
    checks++; if (diff !== 4'b0000) begin errors++; $display("FAIL abort diff: got %b, want 0000", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL abort bout: got %b, want 0", bout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort no_done: got %0d pulses, want 0", seen); end
    checks++; if (diff !== 4'b0000) begin errors++; $display("FAIL abort diff_after: got %b, want 0000", diff); end
    run_op(4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored_start();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
